// File: rtl/serial_subtractor_ctrl_pkg.sv
// serial_sub_pkg: shared definitions for the bit-serial subtractor controller.
//   - state_e   : controller states (IDLE, SHIFT, DONE)
//   - WIDTH_MIN : smallest supported operand width
//   - WIDTH_MAX : largest supported operand width
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int unsigned WIDTH_MIN = 32'd2;
  localparam int unsigned WIDTH_MAX = 32'd32;

endpackage

// File: rtl/serial_subtractor_ctrl_if.sv
// serial_subtractor_ctrl_if: start/done handshake and operand/result bus
// of the bit-serial subtractor.
//   start, a, b          : requester -> subtractor
//   busy, done, diff,
//   borrow_out           : subtractor -> requester
//   zero, eq_lt          : extra result flags, present only when
//                          SERIAL_SUB_FLAGS_EN is defined
// Modports: master (requester side), slave (subtractor side).
interface serial_subtractor_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
`ifdef SERIAL_SUB_FLAGS_EN
  logic             zero;
  logic [1:0]       eq_lt;
`endif

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out
`ifdef SERIAL_SUB_FLAGS_EN
    , input zero, eq_lt
`endif
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out
`ifdef SERIAL_SUB_FLAGS_EN
    , output zero, eq_lt
`endif
  );

endinterface

// File: rtl/serial_subtractor_ctrl_cell.sv
// serial_sub_cell: combinational one-bit full-subtract cell.
//   ai_i, bi_i  : minuend / subtrahend bit
//   br_i        : incoming borrow
//   d_o         : difference bit
//   br_next_o   : outgoing borrow
// Built as two cascaded half-subtractors whose borrows are ORed; the two
// borrows can never both be set, so OR is exact.
module serial_sub_cell (
  input  logic ai_i,
  input  logic bi_i,
  input  logic br_i,
  output logic d_o,
  output logic br_next_o
);

  logic d1_s;
  logic b1_s;
  logic b2_s;

  // first half-subtract: ai - bi
  assign d1_s = ai_i ^ bi_i;
  assign b1_s = ~ai_i & bi_i;

  // second half-subtract: (ai - bi) - br
  assign d_o  = d1_s ^ br_i;
  assign b2_s = ~d1_s & br_i;

  assign br_next_o = b1_s | b2_s;

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// serial_subtractor_ctrl: computes (a - b) mod 2^WIDTH one bit per clock,
// LSB first, reusing a single borrow cell.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : serial_subtractor_ctrl_if.slave (start/a/b in; busy/done/diff/
//          borrow_out out; zero/eq_lt out when SERIAL_SUB_FLAGS_EN defined)
// Parameter WIDTH: operand width, WIDTH_MIN..WIDTH_MAX from serial_sub_pkg.
// Latency from accepted start to done is WIDTH+1 cycles; results are held
// between completions and only update on the edge that enters DONE.
module serial_subtractor_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  serial_subtractor_ctrl_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] d_sh_q, d_sh_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bor_q, bor_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cell_d_s;
  logic             cell_br_s;
`ifdef SERIAL_SUB_FLAGS_EN
  logic             zacc_q, zacc_d;
  logic             zero_q, zero_d;
  logic [1:0]       eq_lt_q, eq_lt_d;
`endif

  serial_sub_cell u_cell (
    .ai_i      (a_sh_q[0]),
    .bi_i      (b_sh_q[0]),
    .br_i      (br_q),
    .d_o       (cell_d_s),
    .br_next_o (cell_br_s)
  );

  // next-state, datapath and output-register next values
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    d_sh_d  = d_sh_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bor_d   = bor_q;
`ifdef SERIAL_SUB_FLAGS_EN
    zacc_d  = zacc_q;
    zero_d  = zero_q;
    eq_lt_d = eq_lt_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          br_d    = 1'b0;
          cnt_d   = {CW{1'b0}};
`ifdef SERIAL_SUB_FLAGS_EN
          zacc_d  = 1'b0;
`endif
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
        d_sh_d = {cell_d_s, d_sh_q[WIDTH-1:1]};
        br_d   = cell_br_s;
        cnt_d  = cnt_q + CNT_ONE;
`ifdef SERIAL_SUB_FLAGS_EN
        zacc_d = zacc_q | cell_d_s;
`endif
        if (cnt_q == CNT_LAST) begin
          // last bit: publish the fully shifted result on this same edge
          diff_d  = {cell_d_s, d_sh_q[WIDTH-1:1]};
          bor_d   = cell_br_s;
`ifdef SERIAL_SUB_FLAGS_EN
          zero_d  = ~(zacc_q | cell_d_s);
          eq_lt_d = {~(zacc_q | cell_d_s), cell_br_s};
`endif
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // busy/done are registered decodes of the state being entered
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  // state, datapath and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= {WIDTH{1'b0}};
      b_sh_q  <= {WIDTH{1'b0}};
      d_sh_q  <= {WIDTH{1'b0}};
      diff_q  <= {WIDTH{1'b0}};
      cnt_q   <= {CW{1'b0}};
      br_q    <= 1'b0;
      bor_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_SUB_FLAGS_EN
      zacc_q  <= 1'b0;
      zero_q  <= 1'b0;
      eq_lt_q <= 2'b00;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      d_sh_q  <= d_sh_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bor_q   <= bor_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_SUB_FLAGS_EN
      zacc_q  <= zacc_d;
      zero_q  <= zero_d;
      eq_lt_q <= eq_lt_d;
`endif
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = bor_q;
`ifdef SERIAL_SUB_FLAGS_EN
  assign bus.zero       = zero_q;
  assign bus.eq_lt      = eq_lt_q;
`endif

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Self-checking bench for serial_subtractor_ctrl: one WIDTH=8 instance for
// directed/random traffic and one WIDTH=4 instance for an exhaustive sweep.
// A cycle-level timeline model (start edge, result edge, next-accept edge)
// predicts every output on every cycle.
module tb_serial_subtractor_ctrl;

  localparam int W8 = 8;
  localparam int W4 = 4;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic rst4 = 1'b1;
  always #5 clk = ~clk;

  serial_subtractor_ctrl_if #(.WIDTH(W8)) bus8 ();
  serial_subtractor_ctrl_if #(.WIDTH(W4)) bus4 ();

  serial_subtractor_ctrl #(.WIDTH(W8)) dut8 (.clk(clk), .rst(rst),  .bus(bus8));
  serial_subtractor_ctrl #(.WIDTH(W4)) dut4 (.clk(clk), .rst(rst4), .bus(bus4));

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // model state per instance (0: WIDTH 8, 1: WIDTH 4)
  int          op_edge[2]   = '{-1, -1};
  int          idle_from[2] = '{0, 0};
  logic [31:0] pend_d[2];
  bit          pend_b[2];
  logic [31:0] exp_diff[2]  = '{32'd0, 32'd0};
  bit          exp_bor[2]   = '{1'b0, 1'b0};
  bit          exp_zero[2]  = '{1'b0, 1'b0};
  bit          exp_busy[2]  = '{1'b0, 1'b0};
  bit          exp_done[2]  = '{1'b0, 1'b0};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // advance the timeline model by one rising edge
  task automatic model_step(input int id, input int w, input bit r, input bit s,
                            input logic [31:0] a, input logic [31:0] b);
    logic [31:0] mask;
    mask = (32'd1 << w) - 32'd1;
    if (r) begin
      op_edge[id]   = -1;
      exp_diff[id]  = 32'd0;
      exp_bor[id]   = 1'b0;
      exp_zero[id]  = 1'b0;
      idle_from[id] = cyc + 1;
    end else begin
      if (op_edge[id] >= 0 && cyc == op_edge[id] + w) begin
        exp_diff[id] = pend_d[id];
        exp_bor[id]  = pend_b[id];
        exp_zero[id] = (pend_d[id] == 32'd0);
      end
      if (s && cyc >= idle_from[id]) begin
        op_edge[id]   = cyc;
        pend_d[id]    = (a - b) & mask;
        pend_b[id]    = (a < b);
        idle_from[id] = cyc + w + 2;
      end
    end
    exp_busy[id] = (op_edge[id] >= 0) && (cyc >= op_edge[id]) && (cyc < op_edge[id] + w);
    exp_done[id] = (op_edge[id] >= 0) && (cyc == op_edge[id] + w);
  endtask

  // model update on each edge, then compare every output shortly after
  always @(posedge clk) begin
    model_step(0, W8, rst,  bus8.start, {24'd0, bus8.a}, {24'd0, bus8.b});
    model_step(1, W4, rst4, bus4.start, {28'd0, bus4.a}, {28'd0, bus4.b});
    cyc++;
    #1;
    chk("w8_busy", {31'd0, bus8.busy}, {31'd0, exp_busy[0]});
    chk("w8_done", {31'd0, bus8.done}, {31'd0, exp_done[0]});
    chk("w8_diff", {24'd0, bus8.diff}, exp_diff[0]);
    chk("w8_borrow", {31'd0, bus8.borrow_out}, {31'd0, exp_bor[0]});
    chk("w4_busy", {31'd0, bus4.busy}, {31'd0, exp_busy[1]});
    chk("w4_done", {31'd0, bus4.done}, {31'd0, exp_done[1]});
    chk("w4_diff", {28'd0, bus4.diff}, exp_diff[1]);
    chk("w4_borrow", {31'd0, bus4.borrow_out}, {31'd0, exp_bor[1]});
`ifdef SERIAL_SUB_FLAGS_EN
    chk("w8_zero", {31'd0, bus8.zero}, {31'd0, exp_zero[0]});
    chk("w8_eq_lt", {30'd0, bus8.eq_lt}, {30'd0, exp_zero[0], exp_bor[0]});
    chk("w4_zero", {31'd0, bus4.zero}, {31'd0, exp_zero[1]});
    chk("w4_eq_lt", {30'd0, bus4.eq_lt}, {30'd0, exp_zero[1], exp_bor[1]});
`endif
  end

  // pulse start for one edge and measure negedges until done (9 expected)
  task automatic op8(input logic [7:0] a, input logic [7:0] b, output int lat);
    bus8.a     = a;
    bus8.b     = b;
    bus8.start = 1'b1;
    lat        = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      bus8.start = 1'b0;
      if (bus8.done && lat < 0) lat = k;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int dn[$];
    bus8.start = 1'b0; bus8.a = 8'd0; bus8.b = 8'd0;
    bus4.start = 1'b0; bus4.a = 4'd0; bus4.b = 4'd0;
    repeat (3) @(negedge clk);
    rst  = 1'b0;
    rst4 = 1'b0;
    chk("rst_busy", {31'd0, bus8.busy}, 32'd0);
    chk("rst_done", {31'd0, bus8.done}, 32'd0);
    chk("rst_diff", {24'd0, bus8.diff}, 32'd0);
    chk("rst_borrow", {31'd0, bus8.borrow_out}, 32'd0);

    op8(8'd5, 8'd3, lat);
    chk("lat_5_3", lat, 32'd9);
    chk("diff_5_3", {24'd0, bus8.diff}, 32'h02);
    chk("bor_5_3", {31'd0, bus8.borrow_out}, 32'd0);
    op8(8'd3, 8'd5, lat);
    chk("diff_3_5", {24'd0, bus8.diff}, 32'hFE);
    chk("bor_3_5", {31'd0, bus8.borrow_out}, 32'd1);
`ifdef SERIAL_SUB_FLAGS_EN
    chk("zero_3_5", {31'd0, bus8.zero}, 32'd0);
    chk("eqlt_3_5", {30'd0, bus8.eq_lt}, 32'd1);
`endif
    op8(8'hFF, 8'hFF, lat);
    chk("diff_ff_ff", {24'd0, bus8.diff}, 32'd0);
    chk("bor_ff_ff", {31'd0, bus8.borrow_out}, 32'd0);
    op8(8'h00, 8'h00, lat);
    chk("diff_0_0", {24'd0, bus8.diff}, 32'd0);
    chk("bor_0_0", {31'd0, bus8.borrow_out}, 32'd0);
`ifdef SERIAL_SUB_FLAGS_EN
    chk("zero_0_0", {31'd0, bus8.zero}, 32'd1);
    chk("eqlt_0_0", {30'd0, bus8.eq_lt}, 32'd2);
`endif

    // start held high with operands changing every cycle
    bus8.start = 1'b1;
    for (int k = 0; k < 45; k++) begin
      bus8.a = 8'($urandom);
      bus8.b = 8'($urandom);
      @(negedge clk);
      if (bus8.done) dn.push_back(cyc);
    end
    bus8.start = 1'b0;
    chk("held_done_count", {31'd0, dn.size() >= 4}, 32'd1);
    for (int i = 1; i < dn.size(); i++) chk("held_period", dn[i] - dn[i-1], 32'd10);
    repeat (12) @(negedge clk);

    // reset four edges into an operation, restart two edges later
    bus8.a = 8'h9A; bus8.b = 8'h21; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", {31'd0, bus8.busy}, 32'd0);
    chk("midrst_done", {31'd0, bus8.done}, 32'd0);
    chk("midrst_diff", {24'd0, bus8.diff}, 32'd0);
    @(negedge clk);
    op8(8'h40, 8'h41, lat);
    chk("restart_lat", lat, 32'd9);
    chk("restart_diff", {24'd0, bus8.diff}, 32'hFF);
    chk("restart_bor", {31'd0, bus8.borrow_out}, 32'd1);

    // random traffic with occasional resets
    for (int k = 0; k < 400; k++) begin
      bus8.start = ($urandom_range(0, 3) == 0);
      bus8.a     = 8'($urandom);
      bus8.b     = 8'($urandom);
      rst        = ($urandom_range(0, 60) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    bus8.start = 1'b0;
    repeat (12) @(negedge clk);

    // exhaustive WIDTH=4 sweep, one operation every 6 cycles
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        bus4.a = 4'(a);
        bus4.b = 4'(b);
        bus4.start = 1'b1;
        @(negedge clk);
        bus4.start = 1'b0;
        repeat (5) @(negedge clk);
      end
    end
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/serial_subtractor_ctrl.md
# serial_subtractor_ctrl

Bit-serial N-bit subtractor controller that computes A − B over WIDTH clock cycles. It uses a single one-bit borrow cell, LSB first, with a start/done handshake. It sits beside the combinational subtractor primitives as the area-minimal sequenced alternative: one subtract cell is reused across all bit positions, and a small FSM, shift registers and a borrow flip-flop drive it.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.

- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend, captured on the accepted start edge
- b  input  WIDTH  subtrahend, captured on the accepted start edge
- busy  output  1  high while bits are being processed (SHIFT state)
- done  output  1  single-cycle pulse; diff/borrow_out are valid from this cycle onward
- diff  output  WIDTH  result (a − b) mod 2^WIDTH, held until the next completion
- borrow_out  output  1  final borrow; 1 when a < b unsigned

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - If start=1, latch a into a_sh and b into b_sh, clear borrow_reg and bit_cnt, then go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, once per cycle:
  - ai=a_sh[0], bi=b_sh[0], br=borrow_reg.
  - d = ai ^ bi ^ br.
  - br_next = (~ai & bi) | (~(ai ^ bi) & br).
  - Shift a_sh and b_sh right by one; shift d into the MSB of d_sh (right shift).
  - borrow_reg ← br_next; bit_cnt increments.
  - When bit_cnt = WIDTH−1, go to DONE.
- DONE, one cycle:
  - diff ← d_sh and borrow_out ← borrow_reg take effect on the entry edge.
  - done=1; next state is IDLE.
- Output hold: diff and borrow_out change only on DONE entry. Partial results are never visible.
- start handling:
  - start in SHIFT or DONE is ignored (not queued).
  - a and b are don't-care except on the accepted start edge.
- Arithmetic is unsigned modulo 2^WIDTH. bit_cnt width is $clog2(WIDTH).

## Timing
- Accepted start on edge T:
  - busy=1 for cycles T+1 .. T+WIDTH.
  - done=1 in cycle T+WIDTH+1 only.
  - Start-to-done latency is WIDTH+1 cycles.
- Back-to-back operation: next start is accepted at the earliest in the cycle after done (first IDLE cycle). Throughput is one result per WIDTH+2 cycles.
- Reset values: state=IDLE, busy=0, done=0, diff=0, borrow_out=0; internal shift registers, bit_cnt and borrow_reg are 0.
- rst mid-operation:
  - The operation is aborted with no done pulse; all outputs return to reset values on that edge.
  - rst takes priority over start in the same cycle.
- busy and done are never high in the same cycle.

## Configuration
- SERIAL_SUB_FLAGS_EN defined:
  - Adds outputs zero (1 bit) and eq_lt (2 bits: {eq, lt}), both registered on DONE entry alongside diff.
  - zero = (final diff == 0); eq = zero; lt = borrow_out.
  - Reset value 0.
  - A zero_acc register clears on accepted start and ORs each d during SHIFT, so no wide compare is needed.
- Not defined: these ports and zero_acc do not exist; all other behaviour is identical.

## Structure
- Package serial_sub_pkg holds:
  - the state enum (IDLE, SHIFT, DONE);
  - the legal WIDTH bounds as constants.
- Sub-module serial_sub_cell: combinational one-bit borrow cell (inputs ai, bi, br; outputs d, br_next). Build it as two cascaded half-subtract stages with an OR of their borrows.
- The top level contains the FSM, shift registers, counter, output registers and the optional flag logic.

## Test plan
- WIDTH=8, a=5, b=3, start pulsed on edge T → done only at T+9, busy T+1..T+8, diff=8'h02, borrow_out=0.
- a=3, b=5 → diff=8'hFE, borrow_out=1; with SERIAL_SUB_FLAGS_EN: zero=0, eq_lt=2'b01.
- a=8'hFF, b=8'hFF, then a=0, b=0 → diff=0, borrow_out=0 both times; with the flag macro: zero=1, eq_lt=2'b10.
- start held high continuously with changing a/b → operands captured only at IDLE edges; results match the captured pairs; done period is 10 cycles.
- rst asserted at T+4 of an operation → no done pulse; busy=0, diff=0 next cycle; a new start at T+6 completes normally with done at T+15.
- Exhaustive sweep at WIDTH=4 of all 256 (a,b) pairs → diff=(a−b)&4'hF and borrow_out=(a<b) for every pair.
